// File: rtl/writeback_serializer.sv
`default_nettype none
// ============================================================================
// writeback_serializer : drains ALU result bundles into a single regfile write
//                        port, one lane per cycle, forwarding pending lanes.
// Revision: 1.0
// ============================================================================
module writeback_serializer #(
  parameter int ALU_NUM = 2,
  parameter int PREG_W  = 6,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ALU_NUM-1:0]        in_we,
  input  logic [ALU_NUM*PREG_W-1:0] in_dst,
  input  logic [ALU_NUM*DATA_W-1:0] in_data,
  output logic [ALU_NUM*PREG_W-1:0] fwd_dst,
  output logic [ALU_NUM*DATA_W-1:0] fwd_data,
  output logic                      rf_we,
  output logic [PREG_W-1:0]         rf_waddr,
  output logic [DATA_W-1:0]         rf_wdata,
  input  logic                      rf_ready,
  output logic [31:0]               retired
);

  localparam int K_W = (ALU_NUM > 1) ? $clog2(ALU_NUM) : 1;

  logic                m_valid_q, m_valid_d;
  logic [PREG_W-1:0]   m_dst_q  [ALU_NUM];
  logic [PREG_W-1:0]   m_dst_d  [ALU_NUM];
  logic [DATA_W-1:0]   m_data_q [ALU_NUM];
  logic [DATA_W-1:0]   m_data_d [ALU_NUM];
  logic [ALU_NUM-1:0]  p_q, p_d;
  logic [31:0]         retired_q, retired_d;

  logic [K_W-1:0]      sel_k;
  logic                has_pend;
  logic                one_hot;
  logic                fire;
  logic                done;
  logic                accept;

  // Lowest pending lane wins, so duplicate destinations retire in lane order.
  always_comb begin
    sel_k = '0;
    for (int i = ALU_NUM - 1; i >= 0; i--) begin
      if (p_q[i]) sel_k = K_W'(i);
    end
  end

  always_comb begin
    has_pend = |p_q;
    one_hot  = has_pend && ((p_q & (p_q - ALU_NUM'(1))) == '0);
    rf_we    = m_valid_q & has_pend & ~flush;
    fire     = rf_we & rf_ready;
    done     = ~has_pend | (one_hot & fire);
    in_ready = ~flush & (~m_valid_q | done);
    accept   = in_valid & in_ready;
    rf_waddr = (m_valid_q & has_pend) ? m_dst_q[sel_k]  : '0;
    rf_wdata = (m_valid_q & has_pend) ? m_data_q[sel_k] : '0;
    retired  = retired_q;
  end

  always_comb begin
    m_valid_d = m_valid_q;
    m_dst_d   = m_dst_q;
    m_data_d  = m_data_q;
    p_d       = p_q;
    retired_d = retired_q + (fire ? 32'd1 : 32'd0);
    if (flush) begin
      m_valid_d = 1'b0;
      p_d       = '0;
    end else if (accept) begin
      m_valid_d = 1'b1;
      for (int i = 0; i < ALU_NUM; i++) begin
        m_dst_d[i]  = in_dst[i*PREG_W +: PREG_W];
        m_data_d[i] = in_data[i*DATA_W +: DATA_W];
        p_d[i]      = in_we[i] & (in_dst[i*PREG_W +: PREG_W] != '0);
      end
    end else begin
      if (fire) p_d[sel_k] = 1'b0;
      if (done) m_valid_d = 1'b0;
    end
  end

  for (genvar g = 0; g < ALU_NUM; g++) begin : g_fwd
    assign fwd_dst[g*PREG_W +: PREG_W]  = (m_valid_q & p_q[g]) ? m_dst_q[g]  : '0;
    assign fwd_data[g*DATA_W +: DATA_W] = (m_valid_q & p_q[g]) ? m_data_q[g] : '0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_valid_q <= 1'b0;
      p_q       <= '0;
      retired_q <= '0;
      for (int i = 0; i < ALU_NUM; i++) begin
        m_dst_q[i]  <= '0;
        m_data_q[i] <= '0;
      end
    end else begin
      m_valid_q <= m_valid_d;
      p_q       <= p_d;
      retired_q <= retired_d;
      m_dst_q   <= m_dst_d;
      m_data_q  <= m_data_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_writeback_serializer.sv
`default_nettype none
// ============================================================================
// tb_writeback_serializer : directed self-checking bench for the serializer.
// Revision: 1.0
// ============================================================================
module tb_writeback_serializer;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_we;
  logic [11:0] in_dst;
  logic [63:0] in_data;
  logic [11:0] fwd_dst;
  logic [63:0] fwd_data;
  logic        rf_we;
  logic [5:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        rf_ready;
  logic [31:0] retired;

  logic [31:0] rf_model [64];
  int          n_total = 0;
  int          n_bad   = 0;

  writeback_serializer #(.ALU_NUM(2), .PREG_W(6), .DATA_W(32)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_we    (in_we),
    .in_dst   (in_dst),
    .in_data  (in_data),
    .fwd_dst  (fwd_dst),
    .fwd_data (fwd_data),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .rf_ready (rf_ready),
    .retired  (retired)
  );

  always #5 clk = ~clk;

  // Regfile consumer model: records accepted writes.
  always @(posedge clk) begin
    if (resetn && rf_we && rf_ready) rf_model[rf_waddr] <= rf_wdata;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [1:0] we, input logic [5:0] d1, input logic [5:0] d0,
                       input logic [31:0] v1, input logic [31:0] v0);
    in_valid = 1'b1;
    in_we    = we;
    in_dst   = {d1, d0};
    in_data  = {v1, v0};
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rf_model[i] = '0;
    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_we = '0;
    in_dst = '0; in_data = '0; rf_ready = 1'b1;
    tick(); tick();
    resetn = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_rf_we",    rf_we, 0);
    check("rst_waddr",    rf_waddr, 0);
    check("rst_wdata",    rf_wdata, 0);
    check("rst_fwd_dst",  fwd_dst, 0);
    check("rst_fwd_data", fwd_data, 0);
    check("rst_retired",  retired, 0);

    // Two-lane bundle, back-to-back acceptance in the last drain cycle.
    offer(2'b11, 6'd9, 6'd5, 32'hB, 32'hA);
    #1; check("b1_in_ready", in_ready, 1);
    tick(); in_valid = 1'b0; #1;
    check("b1c1_we",    rf_we, 1);
    check("b1c1_addr",  rf_waddr, 5);
    check("b1c1_data",  rf_wdata, 32'hA);
    check("b1c1_fwd",   fwd_dst, {6'd9, 6'd5});
    check("b1c1_fdat",  fwd_data, {32'hB, 32'hA});
    check("b1c1_rdy",   in_ready, 0);
    tick(); #1;
    check("b1c2_addr",  rf_waddr, 9);
    check("b1c2_data",  rf_wdata, 32'hB);
    check("b1c2_fwd",   fwd_dst, {6'd9, 6'd0});
    check("b1c2_rdy",   in_ready, 1);
    offer(2'b10, 6'd7, 6'd0, 32'h22, 32'h11);
    tick(); #1;
    check("b1_retired", retired, 2);
    check("rf5", rf_model[5], 32'hA);
    check("rf9", rf_model[9], 32'hB);
    // dst 0 lane is masked: only preg 7 written.
    check("b2_we",   rf_we, 1);
    check("b2_addr", rf_waddr, 7);
    check("b2_data", rf_wdata, 32'h22);
    check("b2_fwd",  fwd_dst, {6'd7, 6'd0});
    check("b2_rdy",  in_ready, 1);
    offer(2'b00, 6'd3, 6'd4, 32'h1, 32'h2);
    tick(); in_valid = 1'b0; #1;
    check("b3_we",      rf_we, 0);
    check("b3_rdy",     in_ready, 1);
    check("b3_fwd",     fwd_dst, 0);
    check("b3_retired", retired, 3);
    tick(); #1;
    check("b3_retired_hold", retired, 3);

    // Stall mid-bundle.
    offer(2'b11, 6'd4, 6'd3, 32'h44, 32'h33);
    tick(); in_valid = 1'b0; #1;
    check("s_c1_addr", rf_waddr, 3);
    tick(); #1;
    rf_ready = 1'b0;
    offer(2'b11, 6'd40, 6'd41, 32'h99, 32'h98);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("stall_addr", rf_waddr, 4);
      check("stall_data", rf_wdata, 32'h44);
      check("stall_fwd",  fwd_dst, {6'd4, 6'd0});
      check("stall_rdy",  in_ready, 0);
      check("stall_we",   rf_we, 1);
      check("stall_ret",  retired, 4);
      tick();
    end
    in_valid = 1'b0; rf_ready = 1'b1; #1;
    check("resume_we",  rf_we, 1);
    check("resume_rdy", in_ready, 1);
    tick(); #1;
    check("resume_ret", retired, 5);
    check("resume_fwd", fwd_dst, 0);
    check("resume_idle_we", rf_we, 0);

    // Flush while lane 1 is pending; a simultaneous offer is dropped.
    offer(2'b11, 6'd21, 6'd20, 32'h21, 32'h20);
    tick(); in_valid = 1'b0; #1;
    check("f_c1_addr", rf_waddr, 20);
    tick();
    flush = 1'b1;
    offer(2'b01, 6'd0, 6'd33, 32'h0, 32'h33);
    #1;
    check("flush_we",  rf_we, 0);
    check("flush_rdy", in_ready, 0);
    tick(); flush = 1'b0; in_valid = 1'b0; #1;
    check("post_flush_fwd", fwd_dst, 0);
    check("post_flush_rdy", in_ready, 1);
    check("post_flush_we",  rf_we, 0);
    check("post_flush_ret", retired, 6);
    check("rf21_untouched", rf_model[21], 0);
    check("rf33_untouched", rf_model[33], 0);

    // Same destination in both lanes: higher lane persists.
    offer(2'b11, 6'd12, 6'd12, 32'd2, 32'd1);
    tick(); in_valid = 1'b0; #1;
    check("dup_c1_data", rf_wdata, 1);
    tick(); #1;
    check("dup_c2_data", rf_wdata, 2);
    tick(); #1;
    check("dup_rf12", rf_model[12], 2);
    check("dup_ret",  retired, 8);

    // Counter wrap.
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    #1;
    check("wrap_pre", retired, 32'hFFFF_FFFF);
    offer(2'b01, 6'd0, 6'd30, 32'h0, 32'h30);
    tick(); in_valid = 1'b0; #1;
    check("wrap_we", rf_we, 1);
    tick(); #1;
    check("wrap_ret", retired, 0);

    // Asynchronous reset mid-drain.
    offer(2'b11, 6'd2, 6'd1, 32'h2, 32'h1);
    tick(); in_valid = 1'b0; #1;
    check("ar_pre_we", rf_we, 1);
    #1; resetn = 1'b0; #1;
    check("ar_we",   rf_we, 0);
    check("ar_fwd",  fwd_dst, 0);
    check("ar_fdat", fwd_data, 0);
    check("ar_ret",  retired, 0);
    check("ar_addr", rf_waddr, 0);
    tick(); resetn = 1'b1; #1;
    check("ar_rdy",  in_ready, 1);
    check("ar_rf1",  rf_model[1], 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/writeback_serializer.md
# writeback_serializer

Drains completed ALU result bundles from execute into the single-write-port physical register file, one lane per cycle. The bundle stays in place until every lane is written, and it drives the forwarding unit's commit-side `dst`/`data` so execute can bypass results that have not reached the register file yet. It sits between the execute stage's ALU outputs and the regfile write port, and it is the producer of the forward path's commit inputs.

## Interface
Parameters:
- `ALU_NUM`, default 2: lanes per bundle; matches execute ALU count.
- `PREG_W`, default 6: physical register address width; preg 0 is hardwired zero.
- `DATA_W`, default 32: result width.

Ports:
- `clk`, input, 1: clock; everything is rising-edge.
- `resetn`, input, 1: asynchronous active-low reset.
- `flush`, input, 1: synchronous kill of the held bundle (mispredict/exception).
- `in_valid`, input, 1: execute offers a bundle.
- `in_ready`, output, 1: bundle is accepted this cycle when `in_valid & in_ready`.
- `in_we`, input, `ALU_NUM`: per-lane write enable.
- `in_dst`, input, `ALU_NUM`×`PREG_W`: per-lane destination preg.
- `in_data`, input, `ALU_NUM`×`DATA_W`: per-lane result.
- `fwd_dst`, output, `ALU_NUM`×`PREG_W`: forward dst; 0 means the lane has no forward.
- `fwd_data`, output, `ALU_NUM`×`DATA_W`: forward data.
- `rf_we`, output, 1: regfile write request.
- `rf_waddr`, output, `PREG_W`: write address.
- `rf_wdata`, output, `DATA_W`: write data.
- `rf_ready`, input, 1: regfile accepts the write this cycle.
- `retired`, output, 32: count of regfile writes accepted.

## Operation
- State:
  - holding register `M`, made of `M_valid`, `M_dst[]` and `M_data[]`;
  - pending mask `P[ALU_NUM]`;
  - counter `retired`.
- Accept:
  - On `in_valid & in_ready & ~flush`, load `M` with the bundle and set `M_valid=1`.
  - Set `P[i] = in_we[i] & (in_dst[i] != 0)`.
- Drain:
  - `rf_we = M_valid & |P & ~flush`.
  - The selected lane `k` is the lowest set bit of `P`. `rf_waddr = M_dst[k]`, `rf_wdata = M_data[k]`.
  - On `rf_we & rf_ready`, clear `P[k]` and increment `retired`. The counter wraps modulo 2^32.
- Done and ready:
  - The bundle is done when `P == 0`, or when `P` is one-hot and `rf_we & rf_ready` this cycle.
  - `in_ready = ~flush & (~M_valid | done)`. This is combinational.
  - If done and no new accept occurs, clear `M_valid` at the clock edge.
  - A bundle with no writing lanes occupies `M` for exactly one cycle.
- Forwarding:
  - `fwd_dst[i] = (M_valid & P[i]) ? M_dst[i] : 0`.
  - `fwd_data[i] = M_valid & P[i] ? M_data[i] : 0`.
  - A lane stops forwarding in the cycle after its write is accepted. It is in the regfile by then.
- Flush:
  - At the clock edge, clear `M_valid` and `P`.
  - In the flush cycle, `rf_we = 0` and `in_ready = 0`. `retired` is not changed.
- Lanes with the same `dst` in one bundle are written in lane order, so the higher lane's value persists.

## Timing
- Reset values:
  - `M_valid = 0`, `P = 0`, `retired = 0`;
  - all `fwd_dst` and `fwd_data` = 0;
  - `rf_we = 0`, `rf_waddr = 0`, `rf_wdata = 0`;
  - `in_ready = 1` once `resetn` is high.
- Latency:
  - A bundle accepted at edge t has its first write visible (`rf_we` high) in cycle t+1.
  - With `rf_ready` held high, an n-writing-lane bundle occupies `M` for n cycles (minimum 1).
  - Back-to-back acceptance is allowed in the last drain cycle, so there are no bubbles.
- `rf_ready` low stalls the drain:
  - `P`, `M` and the forward outputs hold;
  - `in_ready = 0` while `M` is non-empty and not done.
- Reset asserted mid-drain returns all state to reset values immediately (asynchronous). No partial writes are retained.
- Flush and accept in the same cycle: flush wins and nothing is loaded.

## Test plan
- Reset, then a bundle with `we=11`, `dst={5,9}`, `data={0xA,0xB}`, `rf_ready=1`:
  - cycle 1: write 5←0xA, forwards show {5,9};
  - cycle 2: write 9←0xB, forwards show {5→0, 9};
  - new bundle accepted in cycle 2; `retired = 2`.
- Bundle `we=10`, `dst={0,7}`, then `we=00`:
  - the first bundle writes only preg 7 (lane 0 is masked because dst=0);
  - the second occupies 1 cycle with no `rf_we`;
  - `retired` increments by 1.
- `rf_ready` low for 3 cycles mid-bundle:
  - `rf_waddr`, `rf_wdata`, `P` and the forwards are stable;
  - `in_ready = 0`;
  - drain resumes when `rf_ready` rises.
- `flush` while lane 1 is pending:
  - `rf_we = 0` in the flush cycle;
  - next cycle `fwd_dst = {0,0}` and `in_ready = 1`;
  - `retired` is unchanged.
- Both lanes target dst=12 with data {1,2}:
  - writes occur in lane order 1 then 2;
  - the final regfile model holds 2.
- Preload `retired` to 0xFFFFFFFF (run 2^32 writes in the model, or force the value), then one write: `retired` = 0.
